key_entry_controller: RTL and testbench

Front-panel input block for the AES encrypter; the input-side counterpart of the display path. It conditions the raw push-buttons, runs the entry phase machine, and lets the operator dial 16 key bytes and 16 plaintext bytes one at a time. Each committed byte goes to the AES core over a valid/ready write port. It also produces the `cur_phase`, `seven_num` and `set` values that the display controller renders on the seven-segment display and LEDs.

---
 rtl/aes_ui_pkg.sv | 20 ++
 rtl/key_entry_controller_if.sv | 33 +++
 rtl/button_conditioner.sv | 79 +++++++
 rtl/key_entry_controller.sv | 161 ++++++++++++++++
 tb/tb_key_entry_controller.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/aes_ui_pkg.sv
// Shared definitions for the AES front-panel user interface.
// Holds the phase codes that the key entry controller reports and that the
// display controller renders, plus the write-target select encodings used on
// the key/text write port into the AES core.
package aes_ui_pkg;

  // Entry phase codes, also used directly as the FSM state encoding
  typedef enum logic [3:0] {
    PH_IDLE = 4'd0,
    PH_KEY  = 4'd1,
    PH_TEXT = 4'd2,
    PH_RUN  = 4'd3,
    PH_DONE = 4'd4
  } phase_e;

  // Write target select on the AES core write port
  localparam logic WR_SEL_KEY  = 1'b0;
  localparam logic WR_SEL_TEXT = 1'b1;

endpackage

// File: rtl/key_entry_controller_if.sv
// Byte write port between the key entry controller and the AES core.
// Signals:
//   wr_valid - write request, held until accepted
//   wr_ready - core accepts the write this cycle
//   wr_sel   - target, WR_SEL_KEY or WR_SEL_TEXT
//   wr_addr  - byte index within the key or text block
//   wr_data  - byte value
// Modports: master (controller side), slave (AES core side).
interface key_entry_controller_if;

  logic       wr_valid;
  logic       wr_ready;
  logic       wr_sel;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;

  modport master (
    output wr_valid,
    output wr_sel,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_sel,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );

endinterface

// File: rtl/button_conditioner.sv
// Conditions one raw push-button into a single-cycle press pulse.
// Chain: two-flop synchronizer -> optional debouncer -> rising-edge detector.
// Optional feature macro: KEY_ENTRY_DEBOUNCE_EN. When defined, the accepted
// level only follows the synchronized level after it has differed for
// DEBOUNCE_CYCLES consecutive cycles. When undefined, the edge detector runs
// straight off the synchronizer and the press latency is 3 cycles.
// Ports:
//   clk     - clock
//   rst     - asynchronous active-low reset
//   btn_i   - raw asynchronous active-high button
//   press_o - registered one-cycle press pulse
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic press_q;
  logic level;

  // Two-flop synchronizer for the asynchronous button input
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef KEY_ENTRY_DEBOUNCE_EN
  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [CntW-1:0] cnt_q;
  logic            stable_q;

  // Counts consecutive cycles of disagreement; any agreement restarts the count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else if (sync2_q != stable_q) begin
      if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
        stable_q <= sync2_q;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end else begin
      cnt_q <= '0;
    end
  end

  assign level = stable_q;
`else
  assign level = sync2_q;
`endif

  // Rising-edge detector with a registered pulse output
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      prev_q  <= level;
      press_q <= level & ~prev_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/key_entry_controller.sv
// Front-panel key/plaintext entry controller for the AES encrypter.
// Conditions four buttons, runs the entry phase FSM, lets the operator dial
// 16 key bytes and 16 plaintext bytes, and writes each committed byte to the
// AES core over a valid/ready port. Also drives the display-facing values.
// Optional feature macro: KEY_ENTRY_DEBOUNCE_EN (debouncer in each button
// conditioner; without it DEBOUNCE_CYCLES has no effect).
// Ports:
//   clk, rst                    - clock, asynchronous active-low reset
//   btn_inc/dec/next/set        - raw active-high buttons
//   done                        - AES core finished level
//   wr (master)                 - byte write port to the AES core
//   start                       - one-cycle encryption start pulse
//   set                         - one-cycle pulse per accepted set press
//   cur_phase                   - current phase code
//   seven_num                   - byte currently being edited
module key_entry_controller
  import aes_ui_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned NUM_BYTES       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn_inc,
  input  logic                  btn_dec,
  input  logic                  btn_next,
  input  logic                  btn_set,
  input  logic                  done,
  key_entry_controller_if.master wr,
  output logic                  start,
  output logic                  set,
  output logic [3:0]            cur_phase,
  output logic [7:0]            seven_num
);

  localparam logic [3:0] LastIdx = 4'(NUM_BYTES - 1);

  logic incPress, decPress, nextPress, setPress;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc  (.clk(clk), .rst(rst), .btn_i(btn_inc),  .press_o(incPress));
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec  (.clk(clk), .rst(rst), .btn_i(btn_dec),  .press_o(decPress));
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (.clk(clk), .rst(rst), .btn_i(btn_next), .press_o(nextPress));
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set  (.clk(clk), .rst(rst), .btn_i(btn_set),  .press_o(setPress));

  phase_e     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] val_q, val_d;
  logic       wrValid_q, wrValid_d;
  logic       wrSel_q, wrSel_d;
  logic [3:0] wrAddr_q, wrAddr_d;
  logic [7:0] wrData_q, wrData_d;
  logic       start_q, start_d;

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= PH_IDLE;
      idx_q     <= '0;
      val_q     <= '0;
      wrValid_q <= 1'b0;
      wrSel_q   <= WR_SEL_KEY;
      wrAddr_q  <= '0;
      wrData_q  <= '0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      val_q     <= val_d;
      wrValid_q <= wrValid_d;
      wrSel_q   <= wrSel_d;
      wrAddr_q  <= wrAddr_d;
      wrData_q  <= wrData_d;
      start_q   <= start_d;
    end
  end

  // Next-state logic. Inside KEY/TEXT the priority is set > pending write >
  // next > inc/dec, so presses arriving while a write is pending are dropped.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    val_d     = val_q;
    wrValid_d = wrValid_q;
    wrSel_d   = wrSel_q;
    wrAddr_d  = wrAddr_q;
    wrData_d  = wrData_q;
    start_d   = 1'b0;

    case (state_q)
      PH_IDLE: begin
        if (setPress) begin
          state_d = PH_KEY;
          idx_d   = '0;
          val_d   = '0;
        end
      end

      PH_KEY, PH_TEXT: begin
        if (setPress) begin
          state_d   = PH_IDLE;
          idx_d     = '0;
          val_d     = '0;
          wrValid_d = 1'b0;
        end else if (wrValid_q) begin
          if (wr.wr_ready) begin
            wrValid_d = 1'b0;
            val_d     = '0;
            if (idx_q == LastIdx) begin
              idx_d = '0;
              if (state_q == PH_KEY) begin
                state_d = PH_TEXT;
              end else begin
                state_d = PH_RUN;
                start_d = 1'b1;
              end
            end else begin
              idx_d = idx_q + 4'd1;
            end
          end
        end else if (nextPress) begin
          wrValid_d = 1'b1;
          wrSel_d   = (state_q == PH_TEXT) ? WR_SEL_TEXT : WR_SEL_KEY;
          wrAddr_d  = idx_q;
          wrData_d  = val_q;
        end else if (incPress && !decPress) begin
          val_d = val_q + 8'd1;
        end else if (decPress && !incPress) begin
          val_d = val_q - 8'd1;
        end
      end

      PH_RUN: begin
        if (setPress) begin
          state_d = PH_IDLE;
        end else if (done) begin
          state_d = PH_DONE;
        end
      end

      PH_DONE: begin
        if (setPress) begin
          state_d = PH_KEY;
          idx_d   = '0;
          val_d   = '0;
        end
      end

      default: state_d = PH_IDLE;
    endcase
  end

  assign wr.wr_valid = wrValid_q;
  assign wr.wr_sel   = wrSel_q;
  assign wr.wr_addr  = wrAddr_q;
  assign wr.wr_data  = wrData_q;
  assign start       = start_q;
  assign set         = setPress;
  assign cur_phase   = state_q;
  assign seven_num   = val_q;

endmodule

// File: tb/tb_key_entry_controller.sv
// Self-checking bench for key_entry_controller (debouncer macro undefined).
// Expected writes are queued when the next press is issued; a monitor pops
// and compares them whenever the write port handshakes.
module tb_key_entry_controller;
  import aes_ui_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_inc, btn_dec, btn_next, btn_set;
  logic       done;
  logic       start, set;
  logic [3:0] cur_phase;
  logic [7:0] seven_num;

  key_entry_controller_if wrIf();

  key_entry_controller #(
    .DEBOUNCE_CYCLES(4),
    .NUM_BYTES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_inc(btn_inc),
    .btn_dec(btn_dec),
    .btn_next(btn_next),
    .btn_set(btn_set),
    .done(done),
    .wr(wrIf.master),
    .start(start),
    .set(set),
    .cur_phase(cur_phase),
    .seven_num(seven_num)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       sel;
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t expQ[$];
  int  testsRun    = 0;
  int  testsFailed = 0;
  int  writesSeen  = 0;
  int  startSeen   = 0;
  int  setSeen     = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: compare every accepted write against the scoreboard queue
  always @(negedge clk) begin
    if (rst) begin
      if (wrIf.wr_valid && wrIf.wr_ready) begin
        wr_t exp;
        writesSeen++;
        if (expQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL unexpected write: got sel=%0d addr=%0h data=%0h, expected none",
                   wrIf.wr_sel, wrIf.wr_addr, wrIf.wr_data);
        end else begin
          exp = expQ.pop_front();
          checkOutput("write sel",  32'(wrIf.wr_sel),  32'(exp.sel));
          checkOutput("write addr", 32'(wrIf.wr_addr), 32'(exp.addr));
          checkOutput("write data", 32'(wrIf.wr_data), 32'(exp.data));
        end
      end
      if (start) startSeen++;
      if (set) setSeen++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle raw press; returns one cycle after the FSM has reacted
  task automatic applyStimulus(input logic inc, input logic dec, input logic nxt, input logic st);
    btn_inc  = inc;
    btn_dec  = dec;
    btn_next = nxt;
    btn_set  = st;
    tick(1);
    btn_inc  = 1'b0;
    btn_dec  = 1'b0;
    btn_next = 1'b0;
    btn_set  = 1'b0;
    tick(3);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int setBefore;
    rst = 1'b0;
    btn_inc = 1'b0; btn_dec = 1'b0; btn_next = 1'b0; btn_set = 1'b0;
    done = 1'b0;
    wrIf.wr_ready = 1'b0;
    tick(5);
    checkOutput("reset phase",    32'(cur_phase),     32'd0);
    checkOutput("reset seven",    32'(seven_num),     32'd0);
    checkOutput("reset wr_valid", 32'(wrIf.wr_valid), 32'd0);
    checkOutput("reset wr_sel",   32'(wrIf.wr_sel),   32'd0);
    checkOutput("reset wr_addr",  32'(wrIf.wr_addr),  32'd0);
    checkOutput("reset wr_data",  32'(wrIf.wr_data),  32'd0);
    checkOutput("reset start",    32'(start),         32'd0);
    checkOutput("reset set",      32'(set),           32'd0);
    rst = 1'b1;
    tick(2);

    // Wrap behaviour
    applyStimulus(0, 0, 0, 1);
    checkOutput("enter key phase", 32'(cur_phase), 32'd1);
    checkOutput("enter key val",   32'(seven_num), 32'h00);
    applyStimulus(0, 1, 0, 0);
    checkOutput("dec wrap", 32'(seven_num), 32'hFF);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("inc wrap", 32'(seven_num), 32'h01);
    applyStimulus(1, 1, 0, 0);
    checkOutput("inc+dec hold", 32'(seven_num), 32'h01);

    // Handshake with stalled ready
    expQ.push_back({WR_SEL_KEY, 4'd0, 8'h01});
    applyStimulus(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("stall valid", 32'(wrIf.wr_valid), 32'd1);
      checkOutput("stall addr",  32'(wrIf.wr_addr),  32'd0);
      checkOutput("stall data",  32'(wrIf.wr_data),  32'h01);
      tick(1);
    end
    applyStimulus(1, 0, 0, 0);
    checkOutput("inc ignored data",  32'(wrIf.wr_data), 32'h01);
    checkOutput("inc ignored seven", 32'(seven_num),    32'h01);
    wrIf.wr_ready = 1'b1;
    tick(1);
    checkOutput("after xfer valid", 32'(wrIf.wr_valid), 32'd0);
    checkOutput("after xfer seven", 32'(seven_num),     32'h00);
    expQ.push_back({WR_SEL_KEY, 4'd1, 8'h00});
    applyStimulus(0, 0, 1, 0);
    tick(1);
    checkOutput("writes so far", 32'(writesSeen), 32'd2);

    // Abort back to idle, then full key + text entry
    applyStimulus(0, 0, 0, 1);
    checkOutput("abort key phase", 32'(cur_phase), 32'd0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("reenter key", 32'(cur_phase), 32'd1);
    for (int b = 0; b < 16; b++) begin
      repeat (b) applyStimulus(1, 0, 0, 0);
      expQ.push_back({WR_SEL_KEY, 4'(b), 8'(b)});
      applyStimulus(0, 0, 1, 0);
      tick(1);
    end
    checkOutput("text phase", 32'(cur_phase), 32'd2);
    for (int i = 0; i < 16; i++) begin
      repeat (16 - i) applyStimulus(0, 1, 0, 0);
      expQ.push_back({WR_SEL_TEXT, 4'(i), 8'(8'hF0 + i)});
      applyStimulus(0, 0, 1, 0);
      tick(1);
    end
    checkOutput("start pulse",   32'(start),     32'd1);
    checkOutput("run phase",     32'(cur_phase), 32'd3);
    tick(1);
    checkOutput("start low",     32'(start),      32'd0);
    checkOutput("start count",   32'(startSeen),  32'd1);
    checkOutput("full writes",   32'(writesSeen), 32'd34);
    checkOutput("queue drained", 32'(expQ.size()), 32'd0);

    // Completion and restart
    done = 1'b1;
    tick(2);
    checkOutput("done phase", 32'(cur_phase), 32'd4);
    done = 1'b0;
    setBefore = setSeen;
    applyStimulus(0, 0, 0, 1);
    checkOutput("restart phase", 32'(cur_phase),          32'd1);
    checkOutput("restart seven", 32'(seven_num),          32'h00);
    checkOutput("set pulses",    32'(setSeen - setBefore), 32'd1);

    // Abort during a pending text write
    for (int b = 0; b < 16; b++) begin
      expQ.push_back({WR_SEL_KEY, 4'(b), 8'h00});
      applyStimulus(0, 0, 1, 0);
      tick(1);
    end
    checkOutput("text again", 32'(cur_phase), 32'd2);
    wrIf.wr_ready = 1'b0;
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 1, 0);
    checkOutput("pending valid", 32'(wrIf.wr_valid), 32'd1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("abort valid", 32'(wrIf.wr_valid), 32'd0);
    checkOutput("abort phase", 32'(cur_phase),     32'd0);
    wrIf.wr_ready = 1'b1;
    tick(5);
    checkOutput("no write after abort", 32'(writesSeen), 32'd50);

    // Asynchronous reset in the middle of KEY
    applyStimulus(0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0);
    checkOutput("pre-reset seven", 32'(seven_num), 32'h01);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async reset phase", 32'(cur_phase), 32'd0);
    checkOutput("async reset seven", 32'(seven_num), 32'h00);
    tick(2);
    rst = 1'b1;
    tick(2);
    checkOutput("final queue", 32'(expQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
